// File: rtl/mux2_port_arbiter.sv
// Round-robin arbiter that shares one datapath port between two requesters.
// A grant is held until res_done or a watchdog abort, and every output is registered.
module mux2_port_arbiter #(
   parameter int BUS_BITS = 64,
   parameter int TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req0,
   input  logic [BUS_BITS-1:0] data0,
   input  logic                req1,
   input  logic [BUS_BITS-1:0] data1,
   input  logic                res_done,
   output logic                gnt0,
   output logic                gnt1,
   output logic                mux_sel,
   output logic                res_valid,
   output logic [BUS_BITS-1:0] res_data,
   output logic                busy,
   output logic                timeout
);

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   state_t              state_q;
   logic                owner_q;
   logic                last_grant_q;
   logic [7:0]          wd_cnt_q;
   logic                gnt0_q;
   logic                gnt1_q;
   logic                mux_sel_q;
   logic                res_valid_q;
   logic                busy_q;
   logic                timeout_q;
   logic [BUS_BITS-1:0] res_data_q;

   logic                win_any_d;
   logic                winner_d;
   logic [BUS_BITS-1:0] win_data_d;
   logic                wd_expired_d;
   logic [7:0]          wd_cnt_d;

   // A tie goes to whichever requester did not hold the port last.
   always_comb begin
      win_any_d    = req0 | req1;
      winner_d     = (req0 & req1) ? ~last_grant_q : req1;
      win_data_d   = winner_d ? data1 : data0;
      wd_expired_d = (wd_cnt_q == WD_LAST);
      wd_cnt_d     = wd_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         wd_cnt_q     <= 8'd0;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         mux_sel_q    <= 1'b0;
         res_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
         res_data_q   <= '0;
      end else begin
         res_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (win_any_d) begin
                  state_q     <= ST_BUSY;
                  owner_q     <= winner_d;
                  gnt0_q      <= ~winner_d;
                  gnt1_q      <= winner_d;
                  mux_sel_q   <= winner_d;
                  busy_q      <= 1'b1;
                  res_valid_q <= 1'b1;
                  res_data_q  <= win_data_d;
                  wd_cnt_q    <= 8'd0;
               end
            end
            ST_BUSY: begin
               // Completion takes priority over a watchdog expiring on the same edge.
               if (res_done || wd_expired_d) begin
                  state_q      <= ST_IDLE;
                  gnt0_q       <= 1'b0;
                  gnt1_q       <= 1'b0;
                  busy_q       <= 1'b0;
                  last_grant_q <= owner_q;
                  timeout_q    <= ~res_done;
               end else begin
                  wd_cnt_q <= wd_cnt_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign mux_sel   = mux_sel_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign busy      = busy_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_mux2_port_arbiter.sv
// Self-checking bench for mux2_port_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model.
module tb_mux2_port_arbiter;
   localparam int BUS_BITS = 64;
   localparam int TIMEOUT  = 16;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                req0 = 1'b0;
   logic                req1 = 1'b0;
   logic                res_done = 1'b0;
   logic [BUS_BITS-1:0] data0 = '0;
   logic [BUS_BITS-1:0] data1 = '0;
   logic                gnt0, gnt1, mux_sel, res_valid, busy, timeout;
   logic [BUS_BITS-1:0] res_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mux2_port_arbiter #(.BUS_BITS(BUS_BITS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .data0(data0), .req1(req1), .data1(data1),
      .res_done(res_done),
      .gnt0(gnt0), .gnt1(gnt1), .mux_sel(mux_sel), .res_valid(res_valid),
      .res_data(res_data), .busy(busy), .timeout(timeout)
   );

   // Reference model: a transaction is open from its grant edge until res_done or
   // until TIMEOUT edges have elapsed since that grant edge.
   logic                m_busy = 1'b0;
   logic                m_owner = 1'b0;
   logic                m_last = 1'b1;
   logic                m_sel = 1'b0;
   logic                m_valid = 1'b0;
   logic                m_to = 1'b0;
   logic [BUS_BITS-1:0] m_data = '0;
   int                  m_cyc = 0;
   int                  m_start = 0;

   function automatic logic pick(input logic r0, input logic r1, input logic last);
      return (r0 && r1) ? ~last : r1;
   endfunction

   always @(posedge clk) begin
      m_cyc   <= m_cyc + 1;
      m_valid <= 1'b0;
      m_to    <= 1'b0;
      if (reset) begin
         m_busy  <= 1'b0;
         m_owner <= 1'b0;
         m_last  <= 1'b1;
         m_sel   <= 1'b0;
         m_data  <= '0;
      end else if (!m_busy) begin
         if (req0 || req1) begin
            m_busy  <= 1'b1;
            m_owner <= pick(req0, req1, m_last);
            m_sel   <= pick(req0, req1, m_last);
            m_data  <= pick(req0, req1, m_last) ? data1 : data0;
            m_valid <= 1'b1;
            m_start <= m_cyc;
         end
      end else if (res_done) begin
         m_busy <= 1'b0;
         m_last <= m_owner;
      end else if (m_cyc - m_start == TIMEOUT) begin
         m_busy <= 1'b0;
         m_last <= m_owner;
         m_to   <= 1'b1;
      end
   end

   wire [BUS_BITS+5:0] obs  = {gnt0, gnt1, mux_sel, res_valid, busy, timeout, res_data};
   wire [BUS_BITS+5:0] expv = {m_busy & ~m_owner, m_busy & m_owner, m_sel, m_valid,
                               m_busy, m_to, m_data};

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; res_done = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (obs !== '0) begin
         n_bad++; $display("FAIL reset_outputs got=%h exp=0", obs);
      end
      req1 = 1'b1; data1 = 64'd45;
      @(negedge clk);
      n_cmp++;
      if ({gnt0, gnt1, mux_sel, res_valid, busy} !== 5'b01111 || res_data !== 64'd45) begin
         n_bad++; $display("FAIL reset_first_grant got=%h exp gnt1/sel/valid/busy=1 data=45", obs);
      end
      res_done = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (obs !== expv || res_valid !== 1'b0 || gnt1 !== 1'b0) begin
         n_bad++; $display("FAIL reset_first_release got=%h exp=%h", obs, expv);
      end
      req1 = 1'b0; res_done = 1'b0;
      $display("reset: first grant to req1 data=%0d", res_data);
   endtask

   task automatic test_tie_alternation();
      int                  ng = 0;
      int                  since = 0;
      logic                own [4];
      logic [BUS_BITS-1:0] dat [4];
      do_reset();
      req0 = 1'b1; req1 = 1'b1; data0 = 64'd64; data1 = 64'd45;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++; $display("FAIL tie_model cyc=%0d got=%h exp=%h", c, obs, expv);
         end
         if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
            n_bad++; $display("FAIL tie_both_granted cyc=%0d got=11 exp=one-hot", c);
         end
         res_done = 1'b0;
         if (res_valid === 1'b1) begin
            if (ng < 4) begin own[ng] = mux_sel; dat[ng] = res_data; end
            ng++;
            since = 0;
            if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
         end else begin
            since++;
         end
         if (since == 1 && m_busy) res_done = 1'b1;
      end
      n_cmp++;
      if (ng != 4) begin
         n_bad++; $display("FAIL tie_grant_count got=%0d exp=4", ng);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (own[i] !== 1'(i % 2) || dat[i] !== ((i % 2) ? 64'd45 : 64'd64)) begin
               n_bad++;
               $display("FAIL tie_sequence idx=%0d got owner=%0d data=%0d exp owner=%0d data=%0d",
                        i, own[i], dat[i], i % 2, (i % 2) ? 45 : 64);
            end
            $display("tie: grant %0d owner=%0d data=%0d", i, own[i], dat[i]);
         end
      end
   endtask

   task automatic test_fast_completion();
      int ng = 0;
      int last_c = -10;
      do_reset();
      req0 = 1'b1; req1 = 1'b1;
      data0 = {$urandom, $urandom}; data1 = {$urandom, $urandom};
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++; $display("FAIL fast_model cyc=%0d got=%h exp=%h", c, obs, expv);
         end
         res_done = 1'b0;
         if (c == last_c + 1) begin
            n_cmp++;
            if (busy !== 1'b0) begin
               n_bad++; $display("FAIL fast_busy_len cyc=%0d got busy=%0d exp=0", c, busy);
            end
         end
         if (res_valid === 1'b1) begin
            if (ng > 0) begin
               n_cmp++;
               if (c - last_c != 2) begin
                  n_bad++; $display("FAIL fast_spacing got=%0d exp=2", c - last_c);
               end
            end
            $display("fast: grant %0d owner=%0d at cycle %0d", ng, mux_sel, c);
            last_c = c;
            ng++;
            res_done = 1'b1;
         end
      end
      n_cmp++;
      if (ng < 6) begin
         n_bad++; $display("FAIL fast_grant_count got=%0d exp>=6", ng);
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      res_done = 1'b0;
   endtask

   task automatic test_watchdog();
      int t0 = -1;
      int t1 = -1;
      bit fin = 1'b0;
      do_reset();
      req0 = 1'b1; data0 = {$urandom, $urandom}; data1 = {$urandom, $urandom};
      for (int c = 0; c < TIMEOUT + 12 && !fin; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++; $display("FAIL wd_model cyc=%0d got=%h exp=%h", c, obs, expv);
         end
         res_done = 1'b0;
         if (res_valid === 1'b1 && gnt0 === 1'b1 && t0 < 0) begin t0 = c; req1 = 1'b1; end
         if (timeout === 1'b1 && t1 < 0) t1 = c;
         if (t1 >= 0 && c == t1 + 1) begin
            n_cmp++;
            if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || res_data !== data1) begin
               n_bad++; $display("FAIL wd_next_winner got gnt0=%0d gnt1=%0d exp gnt0=0 gnt1=1", gnt0, gnt1);
            end
            req0 = 1'b0; req1 = 1'b0; res_done = 1'b1;
            fin = 1'b1;
         end
      end
      n_cmp++;
      if (t0 < 0 || t1 < 0 || !fin) begin
         n_bad++; $display("FAIL wd_events got t0=%0d t1=%0d exp both seen", t0, t1);
      end else if (t1 - t0 != TIMEOUT) begin
         n_bad++; $display("FAIL wd_latency got=%0d exp=%0d", t1 - t0, TIMEOUT);
      end
      $display("watchdog: grant at %0d timeout at %0d", t0, t1);
      @(negedge clk);
      res_done = 1'b0;
   endtask

   task automatic test_collision();
      int t0 = -1;
      do_reset();
      req1 = 1'b1; data1 = {$urandom, $urandom};
      for (int c = 0; c < TIMEOUT + 6; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++; $display("FAIL coll_model cyc=%0d got=%h exp=%h", c, obs, expv);
         end
         res_done = 1'b0;
         if (res_valid === 1'b1 && t0 < 0) t0 = c;
         if (t0 >= 0 && c == t0 + TIMEOUT - 1) res_done = 1'b1;
         if (t0 >= 0 && c == t0 + TIMEOUT) begin
            n_cmp++;
            if (timeout !== 1'b0 || busy !== 1'b0 || gnt1 !== 1'b0) begin
               n_bad++; $display("FAIL coll_release got timeout=%0d busy=%0d gnt1=%0d exp 0/0/0",
                                 timeout, busy, gnt1);
            end
            req1 = 1'b0;
            $display("collision: done on timeout edge released cleanly at %0d", c);
         end
      end
      n_cmp++;
      if (t0 < 0) begin
         n_bad++; $display("FAIL coll_no_grant got none exp grant");
      end
   endtask

   task automatic test_reset_mid_busy();
      int t0 = -1;
      do_reset();
      req1 = 1'b1; data1 = {$urandom, $urandom}; data0 = {$urandom, $urandom};
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++; $display("FAIL rstbusy_model cyc=%0d got=%h exp=%h", c, obs, expv);
         end
         if (res_valid === 1'b1 && t0 < 0) t0 = c;
         if (t0 >= 0 && c == t0 + 5) res_done = 1'b0;
         if (t0 >= 0 && c == t0 + 4) begin
            n_cmp++;
            if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
               n_bad++; $display("FAIL rstbusy_first_winner got gnt0=%0d gnt1=%0d exp 1/0", gnt0, gnt1);
            end
            req0 = 1'b0; req1 = 1'b0; res_done = 1'b1;
         end
         if (t0 >= 0 && c == t0 + 3) begin
            n_cmp++;
            if (obs !== '0) begin
               n_bad++; $display("FAIL rstbusy_outputs got=%h exp=0", obs);
            end
            reset = 1'b0; res_done = 1'b0;
         end
         if (t0 >= 0 && c == t0 + 2) begin
            reset = 1'b1; res_done = 1'b1; req0 = 1'b1;
         end
      end
      n_cmp++;
      if (t0 < 0) begin
         n_bad++; $display("FAIL rstbusy_no_grant got none exp grant");
      end
      res_done = 1'b0;
      $display("reset_mid_busy: grant at %0d, reset applied mid-transaction", t0);
   endtask

   task automatic test_random();
      int ngrants = 0;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", c, obs, expv);
         end
         if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
            n_bad++; $display("FAIL rand_both_granted cyc=%0d got=11 exp=one-hot", c);
         end
         if (res_valid === 1'b1) ngrants++;
         reset    = ($urandom_range(0, 99) == 0);
         res_done = ($urandom_range(0, 9) == 0);
         req0     = ($urandom_range(0, 2) != 0);
         req1     = ($urandom_range(0, 2) != 0);
         if (m_busy) begin
            if (m_owner) req1 = 1'b1;
            else         req0 = 1'b1;
         end
         if (!req0) data0 = {$urandom, $urandom};
         if (!req1) data1 = {$urandom, $urandom};
      end
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0; res_done = 1'b0;
      $display("random: %0d grants observed", ngrants);
   endtask

   initial begin
      test_reset();
      test_tie_alternation();
      test_fast_completion();
      test_watchdog();
      test_collision();
      test_reset_mid_busy();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux2_port_arbiter.md
# mux2_port_arbiter

Two-requester, round-robin arbiter that shares one `BUS_BITS`-wide datapath port between two requesters (e.g., fetch and data access). It drives the select of the downstream `Mux2` and issues a one-cycle launch strobe with a registered copy of the granted requester's payload to the shared resource. It holds the grant until the resource signals completion, or until a watchdog timeout expires. All outputs are registered.

## Interface
Parameters:
- `BUS_BITS`, 64, width of each requester payload and of `res_data`
- `TIMEOUT`, 16, maximum BUSY cycles without `res_done` before abort; legal range 2..255

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `req0`  in  1  requester 0 request; held high until completion or timeout
- `data0`  in  BUS_BITS  requester 0 payload; stable while `req0` is high
- `req1`  in  1  requester 1 request
- `data1`  in  BUS_BITS  requester 1 payload
- `res_done`  in  1  resource completion pulse for the current grant
- `gnt0`  out  1  requester 0 owns the port (level)
- `gnt1`  out  1  requester 1 owns the port (level)
- `mux_sel`  out  1  select for `Mux2` (0 = in1/requester 0, 1 = in2/requester 1)
- `res_valid`  out  1  one-cycle launch strobe to the resource
- `res_data`  out  BUS_BITS  payload latched at grant time
- `busy`  out  1  high in BUSY
- `timeout`  out  1  one-cycle pulse on watchdog abort

## Operation
- State machine has two states: IDLE and BUSY.
- Internal registers:
  - `owner`: 1 bit.
  - `last_grant`: 1 bit; reset value 1, so requester 0 wins the first tie.
  - `wd_cnt`: 8 bits.
- IDLE, no request: remain in IDLE.
- IDLE, exactly one request: that requester wins.
- IDLE, both requests: winner = `~last_grant`.
- IDLE, on a winner:
  - Go to BUSY.
  - `owner` <= winner; `gnt<winner>` <= 1; `mux_sel` <= winner; `busy` <= 1.
  - `res_valid` <= 1 for exactly one cycle.
  - `res_data` <= winner's data, sampled on the same edge.
  - `wd_cnt` <= 0.
- BUSY, `res_done`=1:
  - Go to IDLE.
  - `gnt0`, `gnt1`, `busy` <= 0.
  - `last_grant` <= `owner`.
  - `mux_sel` and `res_data` hold their last values.
- BUSY, `res_done`=0 and `wd_cnt` == `TIMEOUT`-1:
  - Go to IDLE.
  - `timeout` <= 1 for one cycle.
  - Grants drop; `last_grant` <= `owner`.
- BUSY, otherwise: `wd_cnt` increments, saturating at `TIMEOUT`-1.
- `res_done` is ignored in IDLE, including the launch cycle's own edge; see Timing.
- Requests and payload changes from the non-owner in BUSY have no effect.
- Requester protocol: deassert `req` on the cycle after observing `gnt` with `res_done` or `timeout`. A `req` still high in IDLE is re-arbitrated normally.
- Reset (any state, including mid-BUSY):
  - State IDLE; `last_grant`=1; `owner`=0; `wd_cnt`=0.
  - All outputs 0, including `res_data` and `mux_sel`.
  - Any `res_done` coincident with reset is dropped.

## Timing
- Grant latency: `req` high at edge k (IDLE) -> `gnt`, `busy`, `res_valid`, `mux_sel`, `res_data` valid after edge k.
- `res_valid` falls after edge k+1.
- Earliest completion: `res_done` sampled high at edge k+1 -> grant held for 1 cycle; grants low after edge k+1.
- Turnaround: after release at edge m, IDLE lasts at least one cycle; the next grant appears after edge m+1.
  - Back-to-back service therefore costs 2 cycles minimum per transaction.
- Timeout: with no `res_done`, grant asserted after edge k is released after edge k+`TIMEOUT`.
  - `timeout` is high for the cycle following edge k+`TIMEOUT`.
- `res_done` and timeout on the same edge: `res_done` wins, and `timeout` stays 0.
- Fairness: with both requests held continuously, grants alternate 0,1,0,1...

## Test plan
- **Reset defaults:** reset for 2 cycles -> all outputs 0; then `req1`=1, `data1`=45 -> after next edge `gnt1`=1, `mux_sel`=1, `res_data`=45, `res_valid` high for 1 cycle.
- **Tie and alternation:** `req0`=`req1`=1, `data0`=64, `data1`=45, `res_done` pulsed 2 cycles after each grant, run 4 grants -> owner sequence 0,1,0,1; `res_data` sequence 64,45,64,45; never `gnt0`&`gnt1`.
- **Fast completion:** `res_done` high on the cycle after launch -> BUSY lasts exactly 1 cycle; next grant is 2 cycles after the previous one.
- **Watchdog:** `TIMEOUT`=16, `req0` granted, `res_done` held 0 -> release and `timeout` pulse 16 cycles after grant; `last_grant`=0, so a pending `req1` wins next.
- **Done/timeout collision:** `res_done` asserted exactly on the timeout edge -> normal release, `timeout` stays 0.
- **Reset mid-BUSY:** assert `reset` 3 cycles into a `req1` grant with `res_done` also high -> all outputs 0 next cycle; with both requests held afterward, `req0` wins first.
